// File: rtl/dcache_mem_responder_pkg.sv
// Shared definitions for the data cache miss responder.
// Field offsets match the data cache's req_info packing.
package dcache_mem_responder_pkg;

    localparam int ADDR_MSB  = 148;
    localparam int ADDR_LSB  = 129;
    localparam int STORE_BIT = 128;
    localparam int DATA_MSB  = 127;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dcache_mem_responder_mem_line_array.sv
// Line-granular backing store for the miss responder.
// Synchronous write, combinational read, deliberately not reset.
module dcache_mem_responder_mem_line_array #(
    parameter int NUM_LINES  = 256,
    parameter int LINE_WIDTH = 128,
    parameter int IDX_W      = 8
) (
    input  logic                  clock,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [LINE_WIDTH-1:0] wdata_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [LINE_WIDTH-1:0] rdata_o
);

    logic [LINE_WIDTH-1:0] mem_q [NUM_LINES];

    always_ff @(posedge clock) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the data cache miss port.
// One line request at a time, fixed latency, fill or writeback.
module dcache_mem_responder
    import dcache_mem_responder_pkg::*;
#(
    parameter int MEM_LATENCY = 10,
    parameter int NUM_LINES   = 256,
    parameter int ADDR_WIDTH  = 20,
    parameter int LINE_WIDTH  = 128
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             req_valid,
    input  logic [ADDR_WIDTH+LINE_WIDTH:0]   req_info,
    output logic                             rsp_valid,
    output logic [LINE_WIDTH-1:0]            rsp_data,
    output logic                             rsp_bus_error,
    output logic                             busy,
    output logic                             proto_err
);

    localparam int IDX_W  = (clog2(NUM_LINES) < 1) ? 1 : clog2(NUM_LINES);
    localparam int CNT_W  = clog2(MEM_LATENCY) + 1;
    localparam int INFO_W = ADDR_WIDTH + LINE_WIDTH + 1;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [INFO_W-1:0]     pend_q, pend_d;
    logic                  perr_q, perr_d;

    logic [ADDR_WIDTH-1:0] pend_addr;
    logic                  pend_st;
    logic [LINE_WIDTH-1:0] pend_wdata;
    logic                  in_range;
    logic                  ready;
    logic                  accept;
    logic                  mem_we;
    logic [LINE_WIDTH-1:0] mem_rdata;

    assign pend_addr  = pend_q[ADDR_MSB:ADDR_LSB];
    assign pend_st    = pend_q[STORE_BIT];
    assign pend_wdata = pend_q[DATA_MSB:0];

    // Extra MSB keeps the compare correct when NUM_LINES == 2**ADDR_WIDTH
    assign in_range = {1'b0, pend_addr} < (ADDR_WIDTH+1)'(NUM_LINES);

    assign ready  = (state_q == ST_IDLE) || (state_q == ST_RESP);
    assign accept = req_valid && ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        perr_d  = perr_q | (req_valid & ~ready);
        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
        // RESP doubles as a ready cycle so fills follow writebacks with no bubble
        if (accept) begin
            pend_d  = req_info;
            cnt_d   = CNT_W'(MEM_LATENCY - 1);
            state_d = (MEM_LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            perr_q  <= perr_d;
        end
    end

    assign rsp_valid     = (state_q == ST_RESP);
    assign rsp_bus_error = rsp_valid & ~in_range;
    assign mem_we        = rsp_valid & pend_st & in_range;
    assign rsp_data      = (rsp_valid && in_range && !pend_st) ?
                           mem_rdata : '0;
    assign busy          = (state_q == ST_WAIT);
    assign proto_err     = perr_q;

    dcache_mem_responder_mem_line_array #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WIDTH (LINE_WIDTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clock   (clock),
        .we_i    (mem_we),
        .waddr_i (pend_addr[IDX_W-1:0]),
        .wdata_i (pend_wdata),
        .raddr_i (pend_addr[IDX_W-1:0]),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Bench for dcache_mem_responder: default build plus a MEM_LATENCY=1 build.
// Expected responses come from a line-addressed reference memory.
module tb_dcache_mem_responder;

    localparam int LAT = 10;

    logic         clock = 1'b0;
    logic         reset = 1'b1;

    logic         req_valid = 1'b0;
    logic [148:0] req_info  = '0;
    logic         rsp_valid;
    logic [127:0] rsp_data;
    logic         rsp_err;
    logic         busy;
    logic         perr;

    logic         r1_valid = 1'b0;
    logic [148:0] r1_info  = '0;
    logic         r1_rsp_valid;
    logic [127:0] r1_rsp_data;
    logic         r1_rsp_err;
    logic         r1_busy;
    logic         r1_perr;

    int checks   = 0;
    int failures = 0;

    logic [127:0] mdl  [int];
    logic [127:0] mdl1 [int];

    always #5 clock = ~clock;

    dcache_mem_responder dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_info      (req_info),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_bus_error (rsp_err),
        .busy          (busy),
        .proto_err     (perr)
    );

    dcache_mem_responder #(.MEM_LATENCY(1)) dut1 (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (r1_valid),
        .req_info      (r1_info),
        .rsp_valid     (r1_rsp_valid),
        .rsp_data      (r1_rsp_data),
        .rsp_bus_error (r1_rsp_err),
        .busy          (r1_busy),
        .proto_err     (r1_perr)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; returns at the negedge of the response cycle.
    task automatic txn(input logic [19:0] a, input logic st,
                       input logic [127:0] d, input int inj);
        logic         in_r;
        logic [127:0] ed;
        in_r = (a < 20'd256);
        ed   = (st || !in_r) ? 128'd0 : mdl[int'(a)];
        req_valid = 1'b1;
        req_info  = {a, st, d};
        @(negedge clock);
        req_valid = 1'b0;
        req_info  = '0;
        for (int k = 1; k <= LAT; k++) begin
            if (k > 1) @(negedge clock);
            if (k < LAT) begin
                chk("early_rsp_valid", 128'(rsp_valid), 128'd0);
                chk("idle_rsp_data", rsp_data, 128'd0);
                chk("idle_rsp_err", 128'(rsp_err), 128'd0);
                chk("busy_wait", 128'(busy), 128'd1);
            end else begin
                chk("rsp_valid", 128'(rsp_valid), 128'd1);
                chk("rsp_bus_error", 128'(rsp_err), 128'(!in_r));
                chk("rsp_data", rsp_data, ed);
                chk("busy_resp", 128'(busy), 128'd0);
            end
            if (inj > 0 && k == inj) begin
                req_valid = 1'b1;
                req_info  = {$urandom, $urandom, $urandom, $urandom, $urandom};
            end
            if (inj > 0 && k == inj + 1) begin
                req_valid = 1'b0;
                req_info  = '0;
            end
        end
        if (st && in_r) mdl[int'(a)] = d;
    endtask

    initial begin
        logic [127:0] d0;
        logic [127:0] q_exp_data [$];
        logic         q_exp_err  [$];
        logic [19:0]  a;
        logic         st;
        logic [127:0] d;

        repeat (3) @(negedge clock);
        chk("reset_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("reset_rsp_data", rsp_data, 128'd0);
        chk("reset_rsp_err", 128'(rsp_err), 128'd0);
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_proto_err", 128'(perr), 128'd0);
        chk("reset1_rsp_valid", 128'(r1_rsp_valid), 128'd0);
        reset = 1'b0;
        @(negedge clock);

        // Preload line 5 through the writeback path, then fill it
        txn(20'h00005, 1'b1, {16{8'hA5}}, 0);
        @(negedge clock);
        txn(20'h00005, 1'b0, '0, 0);

        // Store then back-to-back load of the same line
        @(negedge clock);
        txn(20'h00003, 1'b1, 128'h1234, 0);
        txn(20'h00003, 1'b0, '0, 0);

        // Bus error and no aliasing onto line 0
        d0 = {$urandom, $urandom, $urandom, $urandom};
        txn(20'h00000, 1'b1, d0, 0);
        txn(20'h00100, 1'b0, '0, 0);
        txn(20'h00100, 1'b1, ~d0, 0);
        txn(20'h00000, 1'b0, '0, 0);
        txn(20'hFFFFF, 1'b0, '0, 0);

        // Request while busy is ignored and flagged
        @(negedge clock);
        chk("proto_err_before", 128'(perr), 128'd0);
        txn(20'h00005, 1'b0, '0, 3);
        chk("proto_err_set", 128'(perr), 128'd1);
        @(negedge clock);
        txn(20'h00003, 1'b0, '0, 0);
        chk("proto_err_sticky", 128'(perr), 128'd1);

        // Reset mid-request drops it
        @(negedge clock);
        req_valid = 1'b1;
        req_info  = {20'h00005, 1'b0, 128'd0};
        @(negedge clock);
        req_valid = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("after_reset_proto_err", 128'(perr), 128'd0);
        for (int k = 0; k < 15; k++) begin
            chk("dropped_rsp_valid", 128'(rsp_valid), 128'd0);
            chk("dropped_busy", 128'(busy), 128'd0);
            @(negedge clock);
        end
        txn(20'h00005, 1'b0, '0, 0);

        // Randomized traffic against the reference memory
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                a = 20'(256 + $urandom_range(0, 20'hFFFFF - 256));
            end else begin
                a = 20'($urandom_range(0, 7));
            end
            st = 1'($urandom_range(0, 1));
            if (a < 20'd256 && !mdl.exists(int'(a))) st = 1'b1;
            d = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 1) @(negedge clock);
            txn(a, st, d, 0);
        end
        @(negedge clock);
        chk("rand_end_idle", 128'(rsp_valid), 128'd0);

        // MEM_LATENCY=1: continuous requests give a response every cycle
        for (int i = 0; i <= 30; i++) begin
            if (i > 0) begin
                chk("lat1_rsp_valid", 128'(r1_rsp_valid), 128'd1);
                chk("lat1_rsp_err", 128'(r1_rsp_err), 128'(q_exp_err.pop_front()));
                chk("lat1_rsp_data", r1_rsp_data, q_exp_data.pop_front());
                chk("lat1_busy", 128'(r1_busy), 128'd0);
            end
            if (i < 30) begin
                if (i < 8) begin
                    a  = 20'(i);
                    st = 1'b1;
                end else if ($urandom_range(0, 4) == 0) begin
                    a  = 20'(256 + $urandom_range(0, 1000));
                    st = 1'($urandom_range(0, 1));
                end else begin
                    a  = 20'($urandom_range(0, 7));
                    st = 1'($urandom_range(0, 1));
                end
                d = {$urandom, $urandom, $urandom, $urandom};
                q_exp_err.push_back(!(a < 20'd256));
                if (st || !(a < 20'd256)) q_exp_data.push_back(128'd0);
                else q_exp_data.push_back(mdl1[int'(a)]);
                if (st && a < 20'd256) mdl1[int'(a)] = d;
                r1_valid = 1'b1;
                r1_info  = {a, st, d};
            end else begin
                r1_valid = 1'b0;
                r1_info  = '0;
            end
            @(negedge clock);
        end
        chk("lat1_idle", 128'(r1_rsp_valid), 128'd0);
        chk("lat1_proto_err", 128'(r1_perr), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
